// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline slice.
//   XLEN          : datapath / address width
//   NOP_INSTR     : instruction word used for IF/ID bubbles (sll $0,$0,0)
//   PC_INC        : sequential PC increment in bytes
//   fetch_state_t : fetch FSM states (S_REQ = request outstanding,
//                   S_HOLD = word captured while the pipe was stalled)
package cpu_pkg;

    localparam int unsigned    XLEN      = 32;
    localparam logic [31:0]    NOP_INSTR = 32'h0000_0000;
    localparam int unsigned    PC_INC    = 4;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture {instr_i, pc4_i} as a valid instruction
//   bubble_i     : insert NOP_INSTR and clear valid (wins over load_i)
//   instr_i      : instruction word to capture
//   pc4_i        : PC+4 of that instruction
//   instr_o      : registered instruction
//   pc4_o        : registered PC+4
//   valid_o      : register holds a real instruction
// With neither control asserted the register holds its contents.
module ifid_reg #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc4_q;
    logic            valid_q;

    // A bubble leaves pc4 untouched; it is meaningless while valid is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request and loads
// the IF/ID register. Tolerates a multi-cycle imem through a req/ready
// handshake; a word that returns while the pipe is stalled is parked in a
// hold buffer (S_HOLD) until the stall releases.
//   clk, rst                    : clock, asynchronous active-high reset
//   pc_write, ir_write          : hazard unit freezes (either low = stall)
//   flush                       : squash the instruction being fetched
//   pc_src, jmp                 : ID redirect (taken branch / jump)
//   branch_target, jump_target  : redirect addresses (pc_src wins)
//   imem_req, imem_addr         : fetch request and address (= PC)
//   imem_rdata, imem_ready      : returned word, valid when ready
//   ifid_instr, ifid_pc4,
//   ifid_valid                  : IF/ID register contents
//   fetch_busy                  : request outstanding, nothing delivered
module fetch_ifid_stage #(
    parameter int unsigned     XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(cpu_pkg::NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            ir_write,
    input  logic            flush,
    input  logic            pc_src,
    input  logic            jmp,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid,
    output logic            fetch_busy
);

    import cpu_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            req_q;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;

    logic            ifid_load;
    logic            ifid_bubble;
    logic [XLEN-1:0] ifid_src;

    assign stall      = ~pc_write | ~ir_write;
    assign redirect   = pc_src | jmp;
    assign target_raw = pc_src ? branch_target : jump_target;
    // Targets are forced word aligned so pc_q[1:0] stays 00.
    assign target     = {target_raw[XLEN-1:2], 2'b00};
    // Modulo 2^XLEN: the last word of the address space wraps to 0.
    assign pc_inc     = pc_q + XLEN'(PC_INC);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_src    = imem_rdata;

        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    // Returning data (if any) belongs to the wrong path.
                    pc_d        = target;
                    ifid_bubble = ~stall;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    if (imem_ready) pc_d = pc_inc;
                end else if (imem_ready) begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_inc;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            S_HOLD: begin
                ifid_src = hold_q;
                if (redirect) begin
                    pc_d        = target;
                    ifid_bubble = ~stall;
                    state_d     = S_REQ;
                end else if (flush) begin
                    pc_d        = pc_inc;
                    ifid_bubble = 1'b1;
                    state_d     = S_REQ;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_inc;
                    state_d   = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    // imem_req is a registered decode of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            req_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            req_q   <= (state_d == S_REQ);
        end
    end

    ifid_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (ifid_src),
        .pc4_i    (pc_inc),
        .instr_o  (ifid_instr),
        .pc4_o    (ifid_pc4),
        .valid_o  (ifid_valid)
    );

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign fetch_busy = req_q & ~imem_ready;

endmodule
